// File: rtl/rvga_debugbus_if.sv
// Debug bus carrying the decoded fields of one retiring instruction.
// The monitor uses the sink-side modport i.
interface rvga_debugbus_if;
  logic [6:0] opcode;
  logic [2:0] inst_type;
  logic [2:0] brop;
  logic [2:0] ldop;
  logic [1:0] strop;
  logic [3:0] artop;

  modport i (input opcode, inst_type, brop, ldop, strop, artop);
  modport o (output opcode, inst_type, brop, ldop, strop, artop);
endinterface

// File: rtl/rvga_debugbus_monitor.sv
// Retired-instruction monitor: saturating per-class event counters plus a
// trace FIFO of {opcode, subop} entries with a sticky overflow flag.
module rvga_debugbus_monitor #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  rvga_debugbus_if.i       dbg,
  input  logic             dbg_v_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_total_o,
  output logic [CNT_W-1:0] cnt_br_o,
  output logic [CNT_W-1:0] cnt_ld_o,
  output logic [CNT_W-1:0] cnt_st_o,
  output logic [CNT_W-1:0] cnt_art_o,
  output logic             trace_v_o,
  output logic [10:0]      trace_data_o,
  input  logic             trace_rdy_i,
  output logic             trace_ovf_o,
  output logic             cnt_sat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int NC = 5;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  // cls_hit bit order: 0 branch, 1 load, 2 store, 3 arith
  logic [3:0] cls_hit;
  logic [3:0] subop;

  always_comb begin
    cls_hit = 4'b0000;
    subop   = 4'h0;
    case (dbg.opcode)
      OPC_BRANCH: begin
        cls_hit[0] = 1'b1;
        subop      = {1'b0, dbg.brop};
      end
      OPC_LOAD: begin
        cls_hit[1] = 1'b1;
        subop      = {1'b0, dbg.ldop};
      end
      OPC_STORE: begin
        cls_hit[2] = 1'b1;
        subop      = {2'b00, dbg.strop};
      end
      OPC_OP, OPC_OPIMM: begin
        cls_hit[3] = 1'b1;
        subop      = dbg.artop;
      end
      default: ;
    endcase
  end

  // Counter 0 is the total; counters 1..4 follow cls_hit order.
  logic [NC-1:0]    inc;
  logic [NC-1:0]    sat_hit;
  logic [CNT_W-1:0] cnt_val [NC];

  assign inc = {cls_hit, 1'b1} & {NC{dbg_v_i & ~clr_i}};

  for (genvar gi = 0; gi < NC; gi++) begin : g_cnt
    logic [CNT_W-1:0] count;
    logic             at_max;

    assign at_max      = (count == {CNT_W{1'b1}});
    assign sat_hit[gi] = inc[gi] & at_max;
    assign cnt_val[gi] = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        count <= '0;
      end else if (clr_i) begin
        count <= '0;
      end else if (inc[gi] && !at_max) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign cnt_total_o = cnt_val[0];
  assign cnt_br_o    = cnt_val[1];
  assign cnt_ld_o    = cnt_val[2];
  assign cnt_st_o    = cnt_val[3];
  assign cnt_art_o   = cnt_val[4];

  logic sat_flag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_flag <= 1'b0;
    end else if (clr_i) begin
      sat_flag <= 1'b0;
    end else if (|sat_hit) begin
      sat_flag <= 1'b1;
    end
  end

  assign cnt_sat_o = sat_flag;

  // Trace FIFO; the push side ignores clr_i, only the overflow flag is cleared.
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          ovf_flag;

  assign full    = (occ == OW'(DEPTH));
  assign empty   = (occ == '0);
  assign pop     = ~empty & trace_rdy_i;
  assign push_ok = dbg_v_i & (~full | pop);
  assign drop    = dbg_v_i & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= {dbg.opcode, subop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_flag <= 1'b0;
    end else if (clr_i) begin
      ovf_flag <= 1'b0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
    end
  end

  assign trace_ovf_o  = ovf_flag;
  assign trace_v_o    = ~empty;
  assign trace_data_o = empty ? 11'h000 : mem[rd_ptr];

endmodule

// File: tb/tb_rvga_debugbus_monitor.sv
// Directed bench for rvga_debugbus_monitor: a vector table for the basic flow
// plus hand-written overflow, full push/pop, reset and saturation sequences.
module tb_rvga_debugbus_monitor;

  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, v, clr, rdy;
  logic [31:0] total, br, ld, st, art;
  logic tv, ovf, sat;
  logic [10:0] td;

  logic v4, clr4, rdy4;
  logic [3:0] total4, br4, ld4, st4, art4;
  logic tv4, ovf4, sat4;
  logic [10:0] td4;

  rvga_debugbus_if bus ();
  rvga_debugbus_if bus4 ();

  rvga_debugbus_monitor #(.DEPTH(8), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dbg(bus), .dbg_v_i(v), .clr_i(clr),
    .cnt_total_o(total), .cnt_br_o(br), .cnt_ld_o(ld), .cnt_st_o(st), .cnt_art_o(art),
    .trace_v_o(tv), .trace_data_o(td), .trace_rdy_i(rdy),
    .trace_ovf_o(ovf), .cnt_sat_o(sat)
  );

  rvga_debugbus_monitor #(.DEPTH(8), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .dbg(bus4), .dbg_v_i(v4), .clr_i(clr4),
    .cnt_total_o(total4), .cnt_br_o(br4), .cnt_ld_o(ld4), .cnt_st_o(st4), .cnt_art_o(art4),
    .trace_v_o(tv4), .trace_data_o(td4), .trace_rdy_i(rdy4),
    .trace_ovf_o(ovf4), .cnt_sat_o(sat4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Selected class field carries sub; the others carry its complement so a
  // wrong field choice shows up in the trace data.
  task automatic drive(input logic valid, input logic [6:0] op, input logic [3:0] sub);
    v             = valid;
    bus.opcode    = op;
    bus.inst_type = 3'd0;
    bus.brop      = (op == BR) ? sub[2:0] : ~sub[2:0];
    bus.ldop      = (op == LD) ? sub[2:0] : ~sub[2:0];
    bus.strop     = (op == ST) ? sub[1:0] : ~sub[1:0];
    bus.artop     = (op == OP || op == OPI) ? sub : ~sub;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [3:0]  sub;
    logic        rdy;
    logic        clr;
    int          total, br, ld, st, art;
    logic        tv;
    logic [10:0] td;
    logic        ovf;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, BR,   4'h3, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1'b1, 11'h633, 1'b0};
    vecs[1]  = '{1'b1, LD,   4'h2, 1'b0, 1'b0, 2, 1, 1, 0, 0, 1'b1, 11'h633, 1'b0};
    vecs[2]  = '{1'b1, OP,   4'h9, 1'b0, 1'b0, 3, 1, 1, 0, 1, 1'b1, 11'h633, 1'b0};
    vecs[3]  = '{1'b1, JAL,  4'h0, 1'b0, 1'b0, 4, 1, 1, 0, 1, 1'b1, 11'h633, 1'b0};
    vecs[4]  = '{1'b0, 7'h0, 4'h0, 1'b1, 1'b0, 4, 1, 1, 0, 1, 1'b1, 11'h032, 1'b0};
    vecs[5]  = '{1'b0, 7'h0, 4'h0, 1'b1, 1'b0, 4, 1, 1, 0, 1, 1'b1, 11'h339, 1'b0};
    vecs[6]  = '{1'b0, 7'h0, 4'h0, 1'b1, 1'b0, 4, 1, 1, 0, 1, 1'b1, 11'h6F0, 1'b0};
    vecs[7]  = '{1'b0, 7'h0, 4'h0, 1'b1, 1'b0, 4, 1, 1, 0, 1, 1'b0, 11'h000, 1'b0};
    vecs[8]  = '{1'b1, ST,   4'h2, 1'b1, 1'b0, 5, 1, 1, 1, 1, 1'b1, 11'h232, 1'b0};
    vecs[9]  = '{1'b1, OPI,  4'h5, 1'b1, 1'b0, 6, 1, 1, 1, 2, 1'b1, 11'h135, 1'b0};
    vecs[10] = '{1'b0, 7'h0, 4'h0, 1'b1, 1'b0, 6, 1, 1, 1, 2, 1'b0, 11'h000, 1'b0};
    vecs[11] = '{1'b1, BR,   4'h1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b1, 11'h631, 1'b0};
    vecs[12] = '{1'b0, 7'h0, 4'h0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0, 11'h000, 1'b0};
    vecs[13] = '{1'b1, LD,   4'h7, 1'b0, 1'b0, 1, 0, 1, 0, 0, 1'b1, 11'h037, 1'b0};
    vecs[14] = '{1'b0, 7'h0, 4'h0, 1'b0, 1'b0, 1, 0, 1, 0, 0, 1'b1, 11'h037, 1'b0};
    vecs[15] = '{1'b0, 7'h0, 4'h0, 1'b1, 1'b0, 1, 0, 1, 0, 0, 1'b0, 11'h000, 1'b0};

    rst_n = 1'b0; clr = 1'b0; rdy = 1'b0;
    drive(1'b0, 7'h0, 4'h0);
    v4 = 1'b0; clr4 = 1'b0; rdy4 = 1'b1;
    bus4.opcode = LD; bus4.inst_type = 3'd0; bus4.brop = 3'd0;
    bus4.ldop = 3'd4; bus4.strop = 2'd0; bus4.artop = 4'd0;

    #12;
    chk("rst_total", total, 0);
    chk("rst_tv", {31'd0, tv}, 0);
    chk("rst_td", {21'd0, td}, 0);
    chk("rst_flags", {30'd0, ovf, sat}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].sub);
      rdy = vecs[i].rdy;
      clr = vecs[i].clr;
      step();
      $display("vec %0d: v=%0b op=%02h rdy=%0b clr=%0b -> total=%0d br=%0d ld=%0d st=%0d art=%0d tv=%0b td=%03h ovf=%0b",
               i, vecs[i].v, vecs[i].op, vecs[i].rdy, vecs[i].clr, total, br, ld, st, art, tv, td, ovf);
      chk($sformatf("v%0d_total", i), total, vecs[i].total);
      chk($sformatf("v%0d_br", i), br, vecs[i].br);
      chk($sformatf("v%0d_ld", i), ld, vecs[i].ld);
      chk($sformatf("v%0d_st", i), st, vecs[i].st);
      chk($sformatf("v%0d_art", i), art, vecs[i].art);
      chk($sformatf("v%0d_tv", i), {31'd0, tv}, {31'd0, vecs[i].tv});
      chk($sformatf("v%0d_td", i), {21'd0, td}, {21'd0, vecs[i].td});
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
    end
    clr = 1'b0;

    // Overflow: nine pushes into an 8-deep FIFO, then clear while still full
    rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, OP, 4'(i));
      step();
      $display("ovf push %0d: tv=%0b ovf=%0b", i, tv, ovf);
      if (i == 7) chk("ovf_before", {31'd0, ovf}, 0);
      if (i == 8) chk("ovf_after", {31'd0, ovf}, 1);
    end
    drive(1'b1, OP, 4'hF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    $display("clr on full: ovf=%0b total=%0d td=%03h", ovf, total, td);
    chk("clr_ovf", {31'd0, ovf}, 0);
    chk("clr_total", total, 0);
    chk("clr_art", art, 0);
    drive(1'b0, 7'h0, 4'h0);
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_td%0d", i), {21'd0, td}, {21'd0, 7'b0110011, 4'(i)});
      chk($sformatf("drain_tv%0d", i), {31'd0, tv}, 1);
      step();
      $display("drain %0d: tv=%0b td=%03h", i, tv, td);
    end
    chk("drain_empty", {31'd0, tv}, 0);

    // Full FIFO with simultaneous push and pop
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, OP, 4'(i));
      step();
    end
    drive(1'b1, OP, 4'hA);
    rdy = 1'b1;
    step();
    drive(1'b0, 7'h0, 4'h0);
    $display("full push+pop: ovf=%0b td=%03h", ovf, td);
    chk("fpp_ovf", {31'd0, ovf}, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fpp_td%0d", i), {21'd0, td},
          {21'd0, 7'b0110011, (i == 7) ? 4'hA : 4'(i + 1)});
      step();
    end
    chk("fpp_empty", {31'd0, tv}, 0);

    // Asynchronous reset with three queued entries
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BR, 4'(i));
      step();
    end
    drive(1'b0, 7'h0, 4'h0);
    chk("pre_rst_tv", {31'd0, tv}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: tv=%0b td=%03h total=%0d br=%0d", tv, td, total, br);
    chk("arst_tv", {31'd0, tv}, 0);
    chk("arst_td", {21'd0, td}, 0);
    chk("arst_total", total, 0);
    chk("arst_br", br, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, LD, 4'h1);
    step();
    drive(1'b0, 7'h0, 4'h0);
    $display("first push after reset: tv=%0b td=%03h total=%0d", tv, td, total);
    chk("post_rst_tv", {31'd0, tv}, 1);
    chk("post_rst_td", {21'd0, td}, {21'd0, 11'h031});
    chk("post_rst_total", total, 1);

    // Saturation on the 4-bit-counter instance
    v4 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      $display("sat load %0d: ld=%0h total=%0h sat=%0b", i, ld4, total4, sat4);
      if (i == 15) begin
        chk("sat15_ld", {28'd0, ld4}, 32'hF);
        chk("sat15_flag", {31'd0, sat4}, 0);
      end
      if (i == 16) begin
        chk("sat16_ld", {28'd0, ld4}, 32'hF);
        chk("sat16_flag", {31'd0, sat4}, 1);
      end
      if (i == 17) begin
        chk("sat17_ld", {28'd0, ld4}, 32'hF);
        chk("sat17_total", {28'd0, total4}, 32'hF);
      end
    end
    v4 = 1'b0;
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    chk("sat_clr_flag", {31'd0, sat4}, 0);
    chk("sat_clr_ld", {28'd0, ld4}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvga_debugbus_monitor.md
RVGA_DEBUGBUS_MONITOR -- requirements
Module: rvga_debugbus_monitor

Interface
REQ-001 Parameter DEPTH, default 8, sets the trace FIFO entry count; it SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 32, sets the width of every event counter.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port dbg, rvga_debugbus_if.i modport: sink side of the debug bus, carrying opcode(7), inst_type, brop(3), ldop(3), strop(2) and artop(4).
REQ-006 Port dbg_v_i, input, 1 bit: the dbg fields describe one retiring instruction this cycle.
REQ-007 Port clr_i, input, 1 bit: synchronous clear of counters and sticky flags.
REQ-008 Port cnt_total_o, output, CNT_W bits: retired-instruction count.
REQ-009 Ports cnt_br_o, cnt_ld_o, cnt_st_o and cnt_art_o, output, CNT_W bits each: branch, load, store and arithmetic counts.
REQ-010 Port trace_v_o, output, 1 bit: the trace FIFO head is valid.
REQ-011 Port trace_data_o, output, 11 bits: the FIFO head entry, {opcode[6:0], subop[3:0]}.
REQ-012 Port trace_rdy_i, input, 1 bit: the consumer accepts the head entry.
REQ-013 Port trace_ovf_o, output, 1 bit: sticky flag indicating a trace entry was dropped.
REQ-014 Port cnt_sat_o, output, 1 bit: sticky flag indicating some counter saturated.

Function
REQ-015 Classification by dbg.opcode:
  - BRANCH (7'b1100011) SHALL be classed as branch.
  - LOAD (7'b0000011) SHALL be classed as load.
  - STORE (7'b0100011) SHALL be classed as store.
  - OP (7'b0110011) and OP-IMM (7'b0010011) SHALL be classed as arith.
  - All other opcodes SHALL be classed as other.
REQ-016 subop SHALL be the class field zero-extended to 4 bits: brop for branch, ldop for load, strop for store, artop for arith, and 4'h0 for other.
REQ-017 Each cycle with dbg_v_i=1 and clr_i=0:
  - cnt_total_o SHALL increment.
  - The matching class counter SHALL increment.
  - Both SHALL be visible the next cycle (1-cycle latency).
REQ-018 With dbg_v_i=0, all counters SHALL hold.
REQ-019 Counters SHALL saturate at all-ones and never wrap.
REQ-020 The first increment attempted at all-ones SHALL set cnt_sat_o.
REQ-021 clr_i=1 SHALL zero all counters, cnt_sat_o and trace_ovf_o on the next edge.
REQ-022 If clr_i and dbg_v_i are asserted in the same cycle, the clear SHALL win and the instruction SHALL NOT be counted.
REQ-023 clr_i SHALL NOT flush the trace FIFO.
REQ-024 Each dbg_v_i=1 cycle SHALL push {opcode, subop} into the trace FIFO, regardless of clr_i.
REQ-025 A pushed entry SHALL be visible at the head no earlier than the next cycle; the FIFO SHALL have no combinational dbg-to-trace path.
REQ-026 A pop SHALL occur when trace_v_o=1 and trace_rdy_i=1.
REQ-027 trace_data_o SHALL hold stable while trace_v_o=1 and trace_rdy_i=0.
REQ-028 Entries SHALL emerge in push order, and read/write pointers SHALL wrap modulo DEPTH.
REQ-029 FIFO empty: trace_v_o SHALL be 0, and trace_rdy_i SHALL be ignored.
REQ-030 FIFO full with no pop in the same cycle: the incoming entry SHALL be dropped, trace_ovf_o SHALL be set, and stored entries SHALL be unchanged.
REQ-031 FIFO full with a pop in the same cycle: the push SHALL be accepted, no drop SHALL occur, and the occupancy SHALL stay DEPTH.
REQ-032 Simultaneous push and pop at any occupancy SHALL leave the occupancy unchanged.
REQ-033 The occupancy counter SHALL be clog2(DEPTH)+1 bits wide and SHALL range 0..DEPTH.

Reset
REQ-034 While rst_ni=0, regardless of clk_i:
  - All counters SHALL be 0.
  - cnt_sat_o and trace_ovf_o SHALL be 0.
  - The FIFO SHALL be empty, with trace_v_o=0.
  - trace_data_o SHALL be 11'h0.
REQ-035 Reset asserted mid-operation SHALL discard FIFO contents and partial counts immediately.
REQ-036 The first push SHALL be accepted on the first rising edge after rst_ni deasserts.

Verification
REQ-037 Four valid cycles with opcodes BRANCH/brop=3, LOAD/ldop=2, OP/artop=9 and 7'b1101111, with trace_rdy_i=0:
  - The next cycle SHALL show total=4, br=1, ld=1, st=0, art=1.
  - The FIFO SHALL hold 11'h633, 11'h032, 11'h339, 11'h6F0 in order.
REQ-038 DEPTH+1 consecutive pushes with trace_rdy_i=0 SHALL leave occupancy 8 and trace_ovf_o=1, and the ninth entry SHALL be absent on drain.
REQ-039 With the FIFO full, a push and pop in the same cycle SHALL leave trace_ovf_o=0 and the new entry last.
REQ-040 With CNT_W=4 and 16 LOAD pushes:
  - cnt_ld_o SHALL read 4'hF.
  - cnt_sat_o SHALL be 1.
  - A further LOAD SHALL leave cnt_ld_o at 4'hF.
REQ-041 clr_i asserted with dbg_v_i in the same cycle:
  - All counters SHALL read 0.
  - The entry SHALL still appear in the FIFO.
  - trace_ovf_o SHALL be cleared.
REQ-042 rst_ni pulsed low mid-stream with 3 queued entries SHALL give trace_v_o=0 and all counts 0 before the next clock edge.
